cpu_phase_sequencer: RTL and testbench
======================================

Name: cpu_phase_sequencer

Overview:
- Multi-cycle phase controller for the CPU datapath.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Latches the decoded control bits from Control_Unit in DECODE and gates them into the correct phase.
- Owns the shared instruction/data memory port handshake, plus a retired-instruction counter and a memory-timeout error.

Parameters:
- HALT_OPCODE, 4'hF: opcode that parks the sequencer in HALT.
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready before ERROR (1..2^TO_W-1).
- TO_W, 8: timeout counter width.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  instruction opcode from IR, valid from DECODE onward
- jump  in  1  from Control_Unit
- beq  in  1  from Control_Unit
- bne  in  1  from Control_Unit
- mem_read  in  1  from Control_Unit
- mem_write  in  1  from Control_Unit
- reg_write  in  1  from Control_Unit
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write strobe, qualifies mem_req
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target, 3 unused
- reg_write_en  out  1  register file write enable
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6
- retired  out  CNT_W  count of completed instructions, wraps
- error  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - State returns to FETCH immediately.
  - Latched control bits, timeout counter, retired and error all clear to 0.
  - Every output is 0 except state=0.
  - Reset asserted mid-MEM or mid-FETCH abandons the request: mem_req drops asynchronously.
- Output type:
  - Moore outputs decoded from state plus latched bits.
  - Exceptions: ir_write and pc_write in FETCH, and the MEM exit decision, are combinational on mem_ready.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Latch jump, beq, bne, mem_read, mem_write, reg_write.
  - If opcode==HALT_OPCODE, go to HALT; otherwise go to EXEC.
- EXEC (1 cycle), priority order:
  - jump: pc_write=1, pc_src=2, next FETCH.
  - (beq & zero) | (bne & ~zero): pc_write=1, pc_src=1, next FETCH.
  - Branch not taken: next FETCH.
  - Latched mem_read | mem_write: next MEM.
  - reg_write: next WB.
  - Otherwise: next FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we = latched mem_write.
  - On mem_ready: if latched mem_read, go to WB; otherwise go to FETCH.
  - If mem_read and mem_write are both latched, mem_write wins for mem_we and the instruction still goes to WB (read data written back).
- WB (1 cycle): reg_write_en=1, next FETCH.
- Retire:
  - retired increments by 1 on every transition into FETCH from EXEC, MEM or WB.
  - It wraps from 2^CNT_W-1 to 0.
  - The DECODE→HALT transition also counts as retire.
- Timeout:
  - The counter clears on entering FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: go to ERROR, set error=1.
  - mem_ready on the same cycle the count hits MEM_TIMEOUT completes normally (ready wins).
- HALT and ERROR:
  - Terminal states with all strobes 0; exit only through reset.
  - mem_ready is ignored in these states.
- Signals outside their phase:
  - mem_ready outside FETCH/MEM is ignored.
  - Control_Unit inputs are sampled only in DECODE (zero only in EXEC); changes at other times have no effect.
- Every output must be a clean function of state and latched bits (no latches in synthesis).

Test Plan:
- Reset release, mem_ready tied 1, R-type (reg_write=1, others 0) → states 0,1,2,4,0; ir_write and pc_write pulse in cycle 1; reg_write_en high in WB; retired=1 after 5 cycles.
- Load (mem_read=1, reg_write=1), mem_ready low 3 cycles in MEM → mem_req=1 and mem_addr_sel=1 for 4 cycles, mem_we=0, then WB; store (mem_write=1) → mem_we=1 in MEM, no WB, retired +1.
- beq with zero=1 → EXEC asserts pc_write=1, pc_src=1; beq with zero=0 → pc_write=0 in EXEC; bne with zero=0 → pc_src=1; jump=1 with beq=1 → pc_src=2.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 → ERROR after 4 wait cycles, error=1 and sticky, mem_req=0; same test with mem_ready=1 on the 4th cycle → DECODE, error=0.
- opcode=4'hF in DECODE → HALT, retired increments, all strobes 0 for 20 cycles despite mem_ready toggling.
- rst_n pulsed low mid-MEM → mem_req drops in the same cycle (async), state=0 and retired=0; CNT_W=4 with 17 R-type instructions → retired wraps to 1.

Source files
------------

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase controller with shared memory-port
// handshake, retired-instruction counter and sticky memory-timeout error.
module cpu_phase_sequencer #(
  parameter logic [3:0] HALT_OPCODE = 4'hF,
  parameter int         MEM_TIMEOUT = 255,
  parameter int         TO_W        = 8,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             jump,
  input  logic             beq,
  input  logic             bne,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef struct packed {
    logic jump;
    logic beq;
    logic bne;
    logic mem_read;
    logic mem_write;
    logic reg_write;
  } ctl_t;

  // Last wait count tolerated; one more idle cycle past this is a timeout.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  ctl_t             ctl_q, ctl_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             error_q, error_d;

  logic       req_c, we_c, sel_c, irw_c, pcw_c, rwe_c;
  logic [1:0] src_c;
  logic       retire_c;
  logic       br_taken_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctl_q     <= '0;
      to_cnt_q  <= '0;
      retired_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    to_cnt_d   = '0;
    error_d    = error_q;
    req_c      = 1'b0;
    we_c       = 1'b0;
    sel_c      = 1'b0;
    irw_c      = 1'b0;
    pcw_c      = 1'b0;
    src_c      = 2'd0;
    rwe_c      = 1'b0;
    retire_c   = 1'b0;
    br_taken_c = (ctl_q.beq & zero) | (ctl_q.bne & ~zero);

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        ctl_d = '{jump: jump, beq: beq, bne: bne, mem_read: mem_read,
                  mem_write: mem_write, reg_write: reg_write};
        if (opcode == HALT_OPCODE) begin
          state_d  = S_HALT;
          retire_c = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctl_q.jump) begin
          pcw_c   = 1'b1;
          src_c   = 2'd2;
          state_d = S_FETCH;
        end else if (ctl_q.beq | ctl_q.bne) begin
          pcw_c   = br_taken_c;
          src_c   = br_taken_c ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (ctl_q.mem_read | ctl_q.mem_write) begin
          state_d = S_MEM;
        end else if (ctl_q.reg_write) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        req_c = 1'b1;
        sel_c = 1'b1;
        we_c  = ctl_q.mem_write;
        // A load (even one also flagged as a store) writes its data back.
        if (mem_ready) begin
          state_d = ctl_q.mem_read ? S_WB : S_FETCH;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rwe_c   = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (state_d == S_FETCH && state_q inside {S_EXEC, S_MEM, S_WB}) begin
      retire_c = 1'b1;
    end
    retired_d = retire_c ? retired_q + 1'b1 : retired_q;
  end

  // Strobes are gated by rst_n so an in-flight request drops the moment reset asserts.
  assign mem_req      = req_c & rst_n;
  assign mem_we       = we_c & rst_n;
  assign mem_addr_sel = sel_c & rst_n;
  assign ir_write     = irw_c & rst_n;
  assign pc_write     = pcw_c & rst_n;
  assign pc_src       = src_c & {2{rst_n}};
  assign reg_write_en = rwe_c & rst_n;
  assign state        = state_q;
  assign retired      = retired_q;
  assign error        = error_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Randomized self-checking bench for cpu_phase_sequencer against a per-instruction
// phase model built from the instruction-level sequencing rules.
module tb_cpu_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       jump, beq, bne, mem_read, mem_write, reg_write, zero, mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write_en, error;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic [3:0] retired;

  cpu_phase_sequencer #(.HALT_OPCODE(4'hF), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .jump(jump), .beq(beq), .bne(bne),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write_en(reg_write_en),
    .state(state), .retired(retired), .error(error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // One expected cycle: state, strobes {req,we,sel,irw,pcw,src[1:0],rwe}, mem_ready to drive.
  typedef struct {
    logic [2:0] st;
    logic [7:0] sb;
    logic       rdy;
    logic       dec;
    logic       exe;
  } rec_t;

  rec_t       q[$];
  logic [3:0] exp_ret;
  logic [2:0] exp_final;
  logic       cur_j, cur_b, cur_n, cur_mr, cur_mw, cur_rw, cur_z;
  logic [3:0] cur_op;

  function automatic logic [7:0] strobes();
    return {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write_en};
  endfunction

  function automatic void push(input logic [2:0] st, input logic [7:0] sb, input logic rdy,
                               input logic dec, input logic exe);
    rec_t r;
    r.st = st; r.sb = sb; r.rdy = rdy; r.dec = dec; r.exe = exe;
    q.push_back(r);
  endfunction

  // Expected phase sequence of one instruction, from the instruction-level rules.
  task automatic build_instr(input logic j, input logic b, input logic n, input logic mr,
                             input logic mw, input logic rw, input logic z,
                             input logic [3:0] op, input int fwait, input int mwait);
    logic       taken;
    logic [1:0] src;
    q.delete();
    cur_j = j; cur_b = b; cur_n = n; cur_mr = mr; cur_mw = mw; cur_rw = rw; cur_z = z; cur_op = op;
    for (int i = 0; i < fwait; i++) push(3'd0, 8'b1000_0000, 1'b0, 1'b0, 1'b0);
    push(3'd0, 8'b1001_1000, 1'b1, 1'b0, 1'b0);
    push(3'd1, 8'b0, 1'($urandom), 1'b1, 1'b0);
    exp_ret = exp_ret + 4'd1;
    exp_final = 3'd0;
    if (op == 4'hF) begin
      exp_final = 3'd5;
      return;
    end
    taken = j | (b & z) | (n & ~z);
    src = j ? 2'd2 : (taken ? 2'd1 : 2'd0);
    push(3'd2, {4'b0, taken, src, 1'b0}, 1'($urandom), 1'b0, 1'b1);
    if (j | b | n) return;
    if (mr | mw) begin
      for (int i = 0; i < mwait; i++) push(3'd3, {1'b1, mw, 1'b1, 5'b0}, 1'b0, 1'b0, 1'b0);
      push(3'd3, {1'b1, mw, 1'b1, 5'b0}, 1'b1, 1'b0, 1'b0);
      if (mr) push(3'd4, 8'b0000_0001, 1'($urandom), 1'b0, 1'b0);
    end else if (rw) begin
      push(3'd4, 8'b0000_0001, 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  // Plays the queued cycles starting at posedge+1; control inputs carry junk outside DECODE/EXEC.
  task automatic play(input string name, input int limit);
    int cnt;
    cnt = (limit < 0 || limit > q.size()) ? q.size() : limit;
    for (int i = 0; i < cnt; i++) begin
      mem_ready = q[i].rdy;
      {jump, beq, bne, mem_read, mem_write, reg_write} = 6'($urandom);
      opcode = 4'($urandom);
      zero = 1'($urandom);
      if (q[i].dec) begin
        {jump, beq, bne, mem_read, mem_write, reg_write} =
          {cur_j, cur_b, cur_n, cur_mr, cur_mw, cur_rw};
        opcode = cur_op;
      end
      if (q[i].exe) zero = cur_z;
      @(negedge clk);
      n_total++;
      if ({state, strobes()} !== {q[i].st, q[i].sb}) begin
        $display("FAIL %s cyc%0d: got state=%0d strobes=%b, want state=%0d strobes=%b",
                 name, i, state, strobes(), q[i].st, q[i].sb);
      end else n_pass++;
      @(posedge clk); #1;
    end
    if (cnt == q.size()) begin
      n_total++;
      if ({state, retired, error} !== {exp_final, exp_ret, 1'b0}) begin
        $display("FAIL %s end: got state=%0d retired=%0d error=%b, want state=%0d retired=%0d error=0",
                 name, state, retired, error, exp_final, exp_ret);
      end else n_pass++;
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] bits, input logic [3:0] op,
                           input int fw, input int mw);
    build_instr(bits[6], bits[5], bits[4], bits[3], bits[2], bits[1], bits[0], op, fw, mw);
    play(name, -1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {jump, beq, bne, mem_read, mem_write, reg_write, zero, mem_ready} = '0;
    opcode = '0;
    #2;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = '0;
  endtask

  // bits order: {jump, beq, bne, mem_read, mem_write, reg_write, zero}
  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #3;
    n_total++;
    if ({state, strobes(), retired, error} !== 16'd0) begin
      $display("FAIL reset: got state=%0d strobes=%b retired=%0d error=%b, want all 0",
               state, strobes(), retired, error);
    end else n_pass++;
    do_reset();
  endtask

  task automatic test_rtype();
    run_instr("rtype", 7'b0000010, 4'h1, 0, 0);
    run_instr("nop", 7'b0000000, 4'h2, 0, 0);
  endtask

  task automatic test_load_store();
    run_instr("load", 7'b0001010, 4'h3, 0, 3);
    run_instr("store", 7'b0000100, 4'h4, 1, 0);
    run_instr("ld_st_both", 7'b0001100, 4'h5, 0, 2);
  endtask

  task automatic test_branches();
    run_instr("beq_taken", 7'b0100001, 4'h6, 0, 0);
    run_instr("beq_not", 7'b0100000, 4'h6, 0, 0);
    run_instr("bne_taken", 7'b0010000, 4'h7, 0, 0);
    run_instr("bne_not", 7'b0010001, 4'h7, 0, 0);
    run_instr("jump_beq", 7'b1100001, 4'h8, 0, 0);
    run_instr("beq_with_mem", 7'b0101010, 4'h9, 0, 0);
  endtask

  task automatic test_timeout();
    run_instr("fetch_ready_last", 7'b0000010, 4'h1, 3, 0);
    run_instr("mem_ready_last", 7'b0001010, 4'h1, 0, 3);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_total++;
      if ({state, mem_req} !== 4'b0001) begin
        $display("FAIL timeout_wait%0d: got state=%0d mem_req=%b, want state=0 mem_req=1",
                 i, state, mem_req);
      end else n_pass++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      n_total++;
      if ({state, error, strobes(), retired} !== {3'd6, 1'b1, 8'd0, exp_ret}) begin
        $display("FAIL timeout_error%0d: got state=%0d error=%b strobes=%b retired=%0d, want 6 1 0 %0d",
                 i, state, error, strobes(), retired, exp_ret);
      end else n_pass++;
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_halt();
    run_instr("halt", 7'b0000010, 4'hF, 1, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'(i);
      {jump, beq, bne, mem_read, mem_write, reg_write, zero} = 7'($urandom);
      opcode = 4'($urandom);
      @(negedge clk);
      n_total++;
      if ({state, strobes(), retired, error} !== {3'd5, 8'd0, exp_ret, 1'b0}) begin
        $display("FAIL halt_hold%0d: got state=%0d strobes=%b retired=%0d, want 5 0 %0d",
                 i, state, strobes(), retired, exp_ret);
      end else n_pass++;
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    run_instr("pre_rst", 7'b0000010, 4'h1, 0, 0);
    build_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 0, 3);
    play("to_mem", 3);
    mem_ready = 1'b0;
    #2;
    n_total++;
    if ({state, mem_req} !== 4'b0111) begin
      $display("FAIL async_pre: got state=%0d mem_req=%b, want state=3 mem_req=1", state, mem_req);
    end else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({state, mem_req, retired} !== 8'd0) begin
      $display("FAIL async_rst: got state=%0d mem_req=%b retired=%0d, want 0 0 0",
               state, mem_req, retired);
    end else n_pass++;
    do_reset();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) run_instr("wrap_rtype", 7'b0000010, 4'h1, 0, 0);
    n_total++;
    if (retired !== 4'd1) begin
      $display("FAIL wrap: got retired=%0d, want 1", retired);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      run_instr("random", 7'($urandom), 4'($urandom_range(0, 14)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branches();
    test_timeout();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
